// File: rtl/core_run_sequencer.sv
// Purpose: preload core data memory, hold/release core reset, pulse start, watchdog the run, stream a result window back.
// Latency: load beats are written one cycle after acceptance; the first readback beat appears the cycle after core_done.
// Backpressure: load_ready drops once the last beat is taken; readback holds mem_addr/rd_data/rd_last while rd_ready is low.
module core_run_sequencer #(
    parameter int         RESET_CYCLES   = 2,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] RB_BASE        = 8'h00,
    parameter int         RB_LEN         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        mem_sel,
    output logic        mem_wen,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset,
    output logic        core_start,
    input  logic        core_done,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic [15:0] cycles,
    output logic        finished,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RSTC, S_RUN, S_DRAIN, S_FIN, S_ERR
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
    localparam logic [8:0]  RB_LAST     = 9'(RB_LEN - 1);
    localparam bit          RB_EMPTY    = (RB_LEN == 0);

    state_t      state, state_nxt;
    logic [15:0] rst_cnt;
    logic [8:0]  idx, idx_nxt;
    logic [15:0] cycles_inc;
    logic        load_acc;
    logic        rd_acc;

    assign load_acc   = load_valid & load_ready;
    assign rd_acc     = rd_valid & rd_ready;
    assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

    // Readback byte comes straight from memory; forced to zero outside DRAIN so idle outputs read as 0.
    assign rd_data = rd_valid ? mem_rdata : 8'h00;

    // Next-state and readback index; done takes priority over the watchdog in the same cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (load_acc) state_nxt = load_last ? S_RSTC : S_LOAD;
            end
            S_LOAD: begin
                if (load_acc && load_last) state_nxt = S_RSTC;
            end
            S_RSTC: begin
                if (rst_cnt == RST_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    state_nxt = RB_EMPTY ? S_FIN : S_DRAIN;
                    idx_nxt   = 9'd0;
                end else if (cycles_inc >= TIMEOUT_VAL) begin
                    state_nxt = S_ERR;
                end
            end
            S_DRAIN: begin
                if (rd_acc) begin
                    idx_nxt = idx + 9'd1;
                    if (rd_last) state_nxt = S_FIN;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // State, counters and all registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rst_cnt    <= 16'd0;
            idx        <= 9'd0;
            cycles     <= 16'd0;
            load_ready <= 1'b0;
            mem_sel    <= 1'b1;
            mem_wen    <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
            core_reset <= 1'b1;
            core_start <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            finished   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rst_cnt    <= (state == S_RSTC) ? rst_cnt + 16'd1 : 16'd0;
            if (state == S_RUN) cycles <= cycles_inc;
            load_ready <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
            mem_sel    <= (state_nxt != S_RUN);
            core_reset <= (state_nxt != S_RUN);
            core_start <= (state_nxt == S_RUN) && (state != S_RUN);
            rd_valid   <= (state_nxt == S_DRAIN);
            rd_last    <= (state_nxt == S_DRAIN) && (idx_nxt == RB_LAST);
            finished   <= (state_nxt == S_FIN);
            timeout    <= (state_nxt == S_ERR);
            mem_wen    <= load_acc;
            if (load_acc) begin
                mem_addr  <= load_addr;
                mem_wdata <= load_data;
            end else if (state_nxt == S_DRAIN) begin
                mem_addr  <= RB_BASE + idx_nxt[7:0];
            end
        end
    end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Purpose: directed check of the run sequencer: load, reset hold, start, done/watchdog, readback, mid-run reset.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge (half a cycle after the active edge).
// Backpressure: rd_ready is normally high and dropped per table entry to stall a readback beat.
module tb_core_run_sequencer;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
        int         stall;
    } rb_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_last;
    logic [7:0]  load_addr, load_data;
    logic        core_done, rd_ready;
    logic [7:0]  mem_rdata;

    logic        load_ready, mem_sel, mem_wen, core_reset, core_start;
    logic [7:0]  mem_addr, mem_wdata, rd_data;
    logic        rd_valid, rd_last, finished, timeout;
    logic [15:0] cycles;

    logic        load_ready0, mem_sel0, mem_wen0, core_reset0, core_start0;
    logic [7:0]  mem_addr0, mem_wdata0, rd_data0;
    logic        rd_valid0, rd_last0, finished0, timeout0;
    logic [15:0] cycles0;

    logic [7:0]  mem [256];
    bit          mem_inited = 1'b0;

    beat_t       ld_tab [4];
    rb_vec_t     rb_tab [4];

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0, start_cnt = 0, rdv_cnt = 0, rdv0_cnt = 0, acc_cnt = 0;

    always #5 clk = ~clk;

    core_run_sequencer #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(50), .RB_BASE(8'hFE), .RB_LEN(4)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .mem_sel(mem_sel), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .core_start(core_start), .core_done(core_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .cycles(cycles), .finished(finished), .timeout(timeout)
    );

    // Second instance with an empty readback window, driven by the same stimulus.
    core_run_sequencer #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(50), .RB_BASE(8'h00), .RB_LEN(0)) dut0 (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready0), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .mem_sel(mem_sel0), .mem_wen(mem_wen0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(8'h00),
        .core_reset(core_reset0), .core_start(core_start0), .core_done(core_done),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0), .rd_last(rd_last0),
        .cycles(cycles0), .finished(finished0), .timeout(timeout0)
    );

    // Data memory model: preset to addr^5A, then written by the sequencer.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_inited <= 1'b1;
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_wen)    wen_cnt++;
        if (core_start) start_cnt++;
        if (rd_valid)   rdv_cnt++;
        if (rd_valid0)  rdv0_cnt++;
    end
    // Accepted readback beats.
    always @(posedge clk) if (rd_valid && rd_ready) acc_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst_outs(input string nm);
        chk({nm, " flags"}, {23'd0, core_reset, mem_sel, load_ready, mem_wen, core_start,
                             rd_valid, rd_last, finished, timeout}, 32'b1_1000_0000);
        chk({nm, " buses"}, {mem_addr, mem_wdata, rd_data}, 32'h0);
        chk({nm, " cycles"}, {16'd0, cycles}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; core_done = 1'b0; rd_ready = 1'b1;
        #1 chk_rst_outs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input int n);
        int rc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("write wen", {31'd0, mem_wen}, 1);
                chk("write addr/data", {16'd0, mem_addr, mem_wdata}, {16'd0, ld_tab[i-1].addr, ld_tab[i-1].data});
            end
            chk("load_ready open", {31'd0, load_ready}, 1);
            load_valid = 1'b1;
            load_addr  = ld_tab[i].addr;
            load_data  = ld_tab[i].data;
            load_last  = ld_tab[i].last;
        end
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        chk("last write wen", {31'd0, mem_wen}, 1);
        chk("last write addr/data", {16'd0, mem_addr, mem_wdata}, {16'd0, ld_tab[n-1].addr, ld_tab[n-1].data});
        chk("load_ready closed", {31'd0, load_ready}, 0);
        chk("rstc core_reset", {31'd0, core_reset}, 1);
        rc = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_start) break;
            rc++;
        end
        chk("rstc cycles", rc, 2);
    endtask

    task automatic run(input int n);
        int cnt;
        chk("start pulse", {31'd0, core_start}, 1);
        chk("run outputs", {28'd0, core_reset, mem_sel, mem_wen, load_ready}, 0);
        if (n > 0) begin
            for (int k = 1; k <= n; k++) begin
                if (k == n) core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
                if (k < n) @(negedge clk);
            end
            @(negedge clk);
            chk("cycles after done", {16'd0, cycles}, n);
            chk("core_reset after done", {31'd0, core_reset}, 1);
            chk("no timeout", {31'd0, timeout}, 0);
        end else begin
            cnt = 1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (mem_sel) break;
                cnt++;
            end
            chk("watchdog run cycles", cnt, 50);
            chk("timeout flag", {31'd0, timeout}, 1);
            chk("cycles at timeout", {16'd0, cycles}, 50);
            chk("err outputs", {29'd0, core_reset, finished, rd_valid}, 3'b100);
        end
    endtask

    task automatic drain(input int nb);
        int w;
        for (int b = 0; b < nb; b++) begin
            w = 0;
            while (!rd_valid && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (!rd_valid) begin
                chk("rd_valid wait", 0, 1);
                return;
            end
            chk("rb addr", {24'd0, mem_addr}, {24'd0, rb_tab[b].addr});
            chk("rb data", {24'd0, rd_data}, {24'd0, rb_tab[b].data});
            chk("rb last", {31'd0, rd_last}, {31'd0, rb_tab[b].last});
            if (rb_tab[b].stall > 0) begin
                rd_ready = 1'b0;
                for (int s = 0; s < rb_tab[b].stall; s++) begin
                    @(negedge clk);
                    chk("stall hold", {7'd0, rd_valid, rd_last, mem_addr, rd_data, 8'd0},
                        {7'd1, rb_tab[b].last, rb_tab[b].addr, rb_tab[b].data, 8'd0});
                end
                rd_ready = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int wen0, st0, acc0, rdv0, rdvz;
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        core_done = 1'b0; rd_ready = 1'b1;

        // Three-beat load, done on the 20th run cycle, readback FE..01 with a stall on the second beat.
        do_reset();
        wen0 = wen_cnt; st0 = start_cnt; acc0 = acc_cnt;
        ld_tab[0] = '{8'h10, 8'hAA, 1'b0};
        ld_tab[1] = '{8'h11, 8'hBB, 1'b0};
        ld_tab[2] = '{8'h12, 8'hCC, 1'b1};
        load(3);
        run(20);
        rb_tab[0] = '{8'hFE, 8'hA4, 1'b0, 0};
        rb_tab[1] = '{8'hFF, 8'hA5, 1'b0, 3};
        rb_tab[2] = '{8'h00, 8'h5A, 1'b0, 0};
        rb_tab[3] = '{8'h01, 8'h5B, 1'b1, 0};
        drain(4);
        chk("finished A", {30'd0, finished, rd_valid}, 2'b10);
        chk("beats accepted A", acc_cnt - acc0, 4);
        chk("write cycles A", wen_cnt - wen0, 3);
        chk("start pulses A", start_cnt - st0, 1);
        chk("cycles frozen A", {16'd0, cycles}, 20);

        // Load into the readback window, then reset part-way through the drain.
        do_reset();
        ld_tab[0] = '{8'hFE, 8'h11, 1'b0};
        ld_tab[1] = '{8'h00, 8'h22, 1'b0};
        ld_tab[2] = '{8'h01, 8'h33, 1'b1};
        load(3);
        run(5);
        rb_tab[0] = '{8'hFE, 8'h11, 1'b0, 0};
        rb_tab[1] = '{8'hFF, 8'hA5, 1'b0, 0};
        drain(2);
        chk("mid drain valid", {31'd0, rd_valid}, 1);
        reset = 1'b1;
        #1 chk_rst_outs("mid drain reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fresh run after the mid-drain reset completes normally.
        acc0 = acc_cnt;
        ld_tab[0] = '{8'hFF, 8'h44, 1'b1};
        load(1);
        run(7);
        rb_tab[0] = '{8'hFE, 8'h11, 1'b0, 0};
        rb_tab[1] = '{8'hFF, 8'h44, 1'b0, 0};
        rb_tab[2] = '{8'h00, 8'h22, 1'b0, 0};
        rb_tab[3] = '{8'h01, 8'h33, 1'b1, 0};
        drain(4);
        chk("finished C", {30'd0, finished, timeout}, 2'b10);
        chk("beats accepted C", acc_cnt - acc0, 4);

        // Watchdog: done never arrives.
        do_reset();
        rdv0 = rdv_cnt;
        ld_tab[0] = '{8'h20, 8'h01, 1'b1};
        load(1);
        run(0);
        repeat (3) @(negedge clk);
        chk("timeout sticky", {30'd0, timeout, core_reset}, 2'b11);
        chk("no readback on timeout", rdv_cnt - rdv0, 0);

        // Single last beat, done on the first run cycle; empty window instance finishes with no beats.
        do_reset();
        rdvz = rdv0_cnt;
        ld_tab[0] = '{8'h05, 8'h77, 1'b1};
        load(1);
        run(1);
        chk("empty window cycles", {16'd0, cycles0}, 1);
        chk("empty window finished", {31'd0, finished0}, 1);
        @(negedge clk);
        chk("empty window sticky", {30'd0, finished0, rd_valid0}, 2'b10);
        chk("empty window no beats", rdv0_cnt - rdvz, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
- Sits directly upstream of the 9-bit core top level and drives its clk-domain start and reset.
- Preloads data memory from a byte stream, holds the core in reset, then releases it and pulses start.
- Watches done with a watchdog, then streams a result window out of data memory.
- Owns the data-memory port except while the core is running, signalled by mem_sel.

Parameters:
RESET_CYCLES, 2, cycles core_reset is held high after the last load beat (>=1)
TIMEOUT_CYCLES, 4096, RUN cycles allowed before a watchdog abort (<=65535)
RB_BASE, 8'h00, first data-memory address read back
RB_LEN, 8, number of bytes read back (0..256; 0 means no readback)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_valid  in  1  load beat valid
load_ready  out  1  sequencer accepts a load beat
load_addr  in  8  data-memory address of the beat
load_data  in  8  byte to write
load_last  in  1  final load beat
mem_sel  out  1  1 = sequencer owns the data-memory port, 0 = core owns it
mem_wen  out  1  data-memory write enable
mem_addr  out  8  data-memory address
mem_wdata  out  8  data-memory write data
mem_rdata  in  8  data-memory read data (combinational in mem_addr)
core_reset  out  1  reset to the core
core_start  out  1  one-cycle start pulse to the core
core_done  in  1  done from the core
rd_valid  out  1  readback beat valid
rd_ready  in  1  readback consumer ready
rd_data  out  8  readback byte
rd_last  out  1  final readback beat
cycles  out  16  RUN cycle count, saturating
finished  out  1  sticky: run and readback complete
timeout  out  1  sticky: watchdog fired

Behaviour:
States: IDLE, LOAD, RSTC, RUN, DRAIN, FIN, ERR.

Reset (any time, including mid-run):
- State goes to IDLE.
- core_reset=1, mem_sel=1.
- All other outputs are 0; cycles=0; internal counters cleared.

IDLE and LOAD:
- load_ready=1.
- A beat is accepted when load_valid & load_ready.
- An accepted beat is registered and written one cycle later: mem_wen=1, mem_addr=load_addr, mem_wdata=load_data for exactly one cycle.
- First accepted beat moves IDLE to LOAD.
- Beat with load_last=1 (also legal as the very first beat) moves to RSTC. load_ready is 0 from the next cycle.
- The write for the last beat still issues in the first RSTC cycle.

RSTC:
- core_reset=1, mem_sel=1.
- Counts RESET_CYCLES cycles, then moves to RUN.
- core_done is ignored.

RUN:
- First RUN cycle: core_reset=0, core_start=1 (single-cycle pulse), mem_sel=0, mem_wen=0.
- cycles increments every RUN cycle, including the first, and saturates at 16'hFFFF.
- If core_done=1 in a RUN cycle, that cycle is counted and the next state is DRAIN; cycles then freezes.
- Otherwise, when cycles reaches TIMEOUT_CYCLES, the next state is ERR. If done and timeout coincide in the same cycle, done wins.
- load_valid is ignored (load_ready=0).

DRAIN:
- core_reset=1, mem_sel=1, mem_wen=0.
- mem_addr = RB_BASE + idx, using 8-bit wrap-around; rd_data = mem_rdata.
- rd_valid=1 and rd_last=(idx==RB_LEN-1).
- rd_data, rd_last and mem_addr are held stable while rd_valid & !rd_ready.
- idx advances on rd_valid & rd_ready.
- After the beat with rd_last is accepted, move to FIN.
- RB_LEN=0 goes RUN to FIN directly with no beats.

FIN:
- finished=1, core_reset=1.
- Stays in FIN until reset.

ERR:
- timeout=1, core_reset=1, mem_sel=1.
- No readback; stays in ERR until reset.

Outputs are registered except rd_data, which passes mem_rdata through.

Test Plan:
- Load 3 beats (10:AA, 11:BB, 12:CC, last on the third), core asserts done 20 cycles after start -> three one-cycle writes, each a cycle after acceptance; core_reset high for 2 cycles; one core_start pulse; cycles=20; finished=1.
- Readback with RB_BASE=8'hFE, RB_LEN=4 -> mem_addr sequence FE, FF, 00, 01; rd_last only on addr 01.
- rd_ready held low 3 cycles on beat 2 -> rd_data and mem_addr stable; no beat skipped or duplicated.
- core_done never asserted, TIMEOUT_CYCLES=50 -> timeout=1 after exactly 50 RUN cycles; core_reset=1; rd_valid never rises.
- reset asserted mid-DRAIN -> immediate IDLE, all outputs at reset values; a fresh load-run completes normally.
- Single beat with load_last, RB_LEN=0, done on the first RUN cycle -> cycles=1; finished=1 with zero readback beats.
